// File: rtl/vga_pkg.sv
// ============================================================================
// Package  : vga_pkg
// Brief    : 640x480@60 default timing, raster FSM states and colour-bar table
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int CNT_W           = 10;
    localparam int RGB_W           = 24;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_FP_DEF        = 16;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_BP_DEF        = 48;
    localparam int H_TOTAL_DEF     = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF    = 480;
    localparam int V_FP_DEF        = 10;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_BP_DEF        = 33;
    localparam int V_TOTAL_DEF     = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam bit SYNC_POL_DEF    = 1'b0;
    localparam int LOCK_SETTLE_DEF = 1024;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } vga_state_e;

    localparam int             BAR_COUNT   = 8;
    localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;

    function automatic logic [RGB_W-1:0] bar_rgb(input logic [CNT_W-1:0] idx);
        logic [RGB_W-1:0] col;
        case (idx)
            CNT_W'(0): col = RGB_WHITE;
            CNT_W'(1): col = RGB_YELLOW;
            CNT_W'(2): col = RGB_CYAN;
            CNT_W'(3): col = RGB_GREEN;
            CNT_W'(4): col = RGB_MAGENTA;
            CNT_W'(5): col = RGB_RED;
            CNT_W'(6): col = RGB_BLUE;
            default:   col = RGB_BLACK;
        endcase
        return col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lock_sync_settle.sv
// ============================================================================
// Module   : lock_sync_settle
// Brief    : Two-flop pll_lock synchronizer plus continuous-lock settle counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_sync_settle #(
    parameter int LOCK_SETTLE = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_pll_lock,
    output logic o_lock_s,
    output logic o_lock_ok
);

    localparam int                c_cnt_w      = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_max = c_cnt_w'(LOCK_SETTLE - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_cnt_w-1:0] r_settle_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_pll_lock;
            r_sync <= r_meta;
        end
    end

    // Any synced drop of lock restarts the settle window; saturates once settled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_settle_cnt <= '0;
        end else if (!r_sync) begin
            r_settle_cnt <= '0;
        end else if (r_settle_cnt != c_settle_max) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    assign o_lock_s  = r_sync;
    assign o_lock_ok = r_sync && (r_settle_cnt == c_settle_max);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing generator gated by settled PLL lock
// Options  : VGA_TEST_PATTERN_EN adds a 24-bit colour-bar output (rgb)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_POL    = SYNC_POL_DEF,
    parameter int LOCK_SETTLE = LOCK_SETTLE_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_lock,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [RGB_W-1:0] rgb
`endif
);

    localparam logic [CNT_W-1:0] c_h_act      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_hs_start   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_hs_end     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] c_v_act      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_vs_start   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_vs_end     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic             w_lock_s;
    logic             w_lock_ok;
    vga_state_e       r_state;
    vga_state_e       w_state_nxt;
    logic             w_active;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_de_nxt;
    logic             w_hs_on;
    logic             w_vs_on;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [CNT_W-1:0] r_pix_x;
    logic [CNT_W-1:0] r_pix_y;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_running;

    lock_sync_settle #(
        .LOCK_SETTLE (LOCK_SETTLE)
    ) u_lock (
        .clk        (clk),
        .resetn     (resetn),
        .i_pll_lock (pll_lock),
        .o_lock_s   (w_lock_s),
        .o_lock_ok  (w_lock_ok)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_LOCK: if (w_lock_s) w_state_nxt = SETTLE;
            SETTLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (w_lock_ok) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:       if (!w_lock_s) w_state_nxt = WAIT_LOCK;
            default:   w_state_nxt = WAIT_LOCK;
        endcase
    end

    // Qualifying with lock_s makes the outputs go idle on the very edge that sees lock drop.
    assign w_active = (r_state == RUN) && w_lock_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h <= '0;
            r_v <= '0;
        end else if (!w_active) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_de_nxt = (r_h < c_h_act) && (r_v < c_v_act);
    assign w_hs_on  = (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_vs_on  = (r_v >= c_vs_start) && (r_v < c_vs_end);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else if (w_active) begin
            r_hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_de_nxt;
            r_pix_x       <= r_h;
            r_pix_y       <= r_v;
            r_line_start  <= (r_h == '0);
            r_frame_start <= (r_h == '0) && (r_v == '0);
            r_running     <= 1'b1;
        end else begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign running     = r_running;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] c_bar_w = CNT_W'(H_ACTIVE / BAR_COUNT);

    logic [CNT_W-1:0] w_bar_idx;
    logic [RGB_W-1:0] r_rgb;

    assign w_bar_idx = r_h / c_bar_w;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rgb <= '0;
        end else if (w_active && w_de_nxt) begin
            r_rgb <= bar_rgb(w_bar_idx);
        end else begin
            r_rgb <= '0;
        end
    end

    assign rgb = r_rgb;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Vertical timing is shortened to 29 lines/frame
// (20 active, FP 3, sync 2, BP 4); horizontal and lock-settle timing use defaults.
`default_nettype none

module tb_vga_timing_gen;

    localparam int LINE  = 800;
    localparam int FRAME = 29 * LINE;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       hsync, vsync, de, line_start, frame_start, running;
    logic [9:0] pix_x, pix_y;
`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] rgb;
`endif

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    vga_timing_gen #(
        .V_ACTIVE (20),
        .V_FP     (3),
        .V_SYNC   (2),
        .V_BP     (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pll_lock    (pll_lock),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .rgb         (rgb)
`endif
    );

    initial begin
        #(40 * 150000);
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic test_reset();
        resetn = 1'b0;
        pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vsync); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de got %b exp 0", de); end
        checks++; if (line_start !== 1'b0) begin errors++; $display("FAIL reset_line_start got %b exp 0", line_start); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin errors++; $display("FAIL reset_pix got %0d,%0d exp 0,0", pix_x, pix_y); end
    endtask

    task automatic test_startup();
        int n = 0;
        resetn = 1'b1;
        do begin @(negedge clk); n++; end while (running !== 1'b1 && n < 1200);
        checks++; if (n < 1025 || n > 1027) begin errors++; $display("FAIL startup_latency got %0d exp 1026+-1", n); end
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL startup_de got %b exp 1", de); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL startup_frame_start got %b exp 1", frame_start); end
        checks++; if (line_start !== 1'b1) begin errors++; $display("FAIL startup_line_start got %b exp 1", line_start); end
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin errors++; $display("FAIL startup_pix got %0d,%0d exp 0,0", pix_x, pix_y); end
    endtask

    task automatic test_line();
        int de_cnt = 0;
        int hs_cnt = 0;
        int ls_cnt = 0;
        int hs_first = -1;
        int hs_last = -1;
        for (int i = 0; i < LINE; i++) begin
            if (de === 1'b1) de_cnt++;
            if (hsync === 1'b0) begin
                if (hs_first < 0) hs_first = int'(pix_x);
                hs_last = int'(pix_x);
                hs_cnt++;
            end
            if (line_start === 1'b1) ls_cnt++;
            @(negedge clk);
        end
        checks++; if (de_cnt != 640) begin errors++; $display("FAIL line_de_count got %0d exp 640", de_cnt); end
        checks++; if (hs_cnt != 96) begin errors++; $display("FAIL line_hsync_width got %0d exp 96", hs_cnt); end
        checks++; if (hs_first != 656) begin errors++; $display("FAIL line_hsync_start got %0d exp 656", hs_first); end
        checks++; if (hs_last != 751) begin errors++; $display("FAIL line_hsync_end got %0d exp 751", hs_last); end
        checks++; if (ls_cnt != 1) begin errors++; $display("FAIL line_start_count got %0d exp 1", ls_cnt); end
        checks++; if (line_start !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd1) begin
            errors++; $display("FAIL line_period got ls=%b x=%0d y=%0d exp ls=1 x=0 y=1", line_start, pix_x, pix_y);
        end
    endtask

    task automatic test_frame();
        int n = 0;
        int vs_cnt = 0;
        int vs_first_y = -1;
        int vs_first_x = -1;
        int misalign = 0;
        int de_lines = 0;
        int fs_cnt = 0;
        logic vs_prev;
        while (frame_start !== 1'b1 && n < FRAME + LINE) begin @(negedge clk); n++; end
        checks++; if (n != FRAME - LINE) begin errors++; $display("FAIL frame_wait got %0d exp %0d", n, FRAME - LINE); end
        vs_prev = vsync;
        for (int i = 0; i < FRAME; i++) begin
            if (vsync === 1'b0) begin
                if (vs_first_y < 0) begin vs_first_y = int'(pix_y); vs_first_x = int'(pix_x); end
                vs_cnt++;
            end
            if (vsync !== vs_prev && line_start !== 1'b1) misalign++;
            vs_prev = vsync;
            if (line_start === 1'b1 && de === 1'b1) de_lines++;
            if (frame_start === 1'b1) fs_cnt++;
            @(negedge clk);
        end
        checks++; if (vs_cnt != 1600) begin errors++; $display("FAIL frame_vsync_width got %0d exp 1600", vs_cnt); end
        checks++; if (vs_first_y != 23 || vs_first_x != 0) begin errors++; $display("FAIL frame_vsync_start got y=%0d x=%0d exp y=23 x=0", vs_first_y, vs_first_x); end
        checks++; if (misalign != 0) begin errors++; $display("FAIL frame_vsync_align got %0d exp 0", misalign); end
        checks++; if (de_lines != 20) begin errors++; $display("FAIL frame_de_lines got %0d exp 20", de_lines); end
        checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count got %0d exp 1", fs_cnt); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_period got %b exp 1", frame_start); end
    endtask

    task automatic test_lock_loss();
        int n = 0;
        while (!(de === 1'b1 && pix_x == 10'd300 && pix_y == 10'd10) && n < FRAME) begin @(negedge clk); n++; end
        checks++; if (n >= FRAME) begin errors++; $display("FAIL lock_loss_reach got %0d exp <%0d", n, FRAME); end
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (de !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL lock_loss_idle got de=%b run=%b exp 0,0", de, running); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL lock_loss_sync got hs=%b vs=%b exp 1,1", hsync, vsync); end
        checks++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL lock_loss_strobe got ls=%b fs=%b exp 0,0", line_start, frame_start); end
        repeat (20) @(negedge clk);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL lock_loss_hold got %b exp 0", running); end
        pll_lock = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (running !== 1'b1 && n < 1200);
        checks++; if (n < 1025 || n > 1027) begin errors++; $display("FAIL relock_latency got %0d exp 1026+-1", n); end
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0 || frame_start !== 1'b1 || de !== 1'b1) begin
            errors++; $display("FAIL relock_origin got x=%0d y=%0d fs=%b de=%b exp 0,0,1,1", pix_x, pix_y, frame_start, de);
        end
    endtask

    task automatic test_settle_abort();
        int hi = 0;
        int n = 0;
        pll_lock = 1'b0;
        repeat (10) @(negedge clk);
        pll_lock = 1'b1;
        repeat (500) begin @(negedge clk); if (running !== 1'b0) hi++; end
        pll_lock = 1'b0;
        repeat (4) begin @(negedge clk); if (running !== 1'b0) hi++; end
        checks++; if (hi != 0) begin errors++; $display("FAIL settle_abort_running got %0d exp 0", hi); end
        pll_lock = 1'b1;
        do begin @(negedge clk); n++; end while (running !== 1'b1 && n < 1200);
        checks++; if (n < 1025 || n > 1027) begin errors++; $display("FAIL settle_restart got %0d exp 1026+-1", n); end
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin errors++; $display("FAIL settle_origin got %0d,%0d exp 0,0", pix_x, pix_y); end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int          xs   [7] = '{0, 80, 200, 320, 500, 639, 700};
        logic [23:0] exps [7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h0000FF, 24'h000000, 24'h000000};
        for (int i = 0; i < LINE; i++) begin
            for (int k = 0; k < 7; k++) begin
                if (i == xs[k]) begin
                    checks++;
                    if (rgb !== exps[k] || int'(pix_x) != i) begin
                        errors++; $display("FAIL pattern_x%0d got rgb=%h x=%0d exp rgb=%h", i, rgb, pix_x, exps[k]);
                    end
                end
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_async_reset();
        int n = 0;
        while (!(de === 1'b1 && pix_x == 10'd100) && n < 2 * LINE) begin @(negedge clk); n++; end
        checks++; if (n >= 2 * LINE) begin errors++; $display("FAIL async_reach got %0d exp <%0d", n, 2 * LINE); end
        #5;
        resetn = 1'b0;
        #1;
        checks++; if (de !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL async_idle got de=%b run=%b exp 0,0", de, running); end
        checks++; if (pix_x !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL async_values got x=%0d hs=%b vs=%b exp 0,1,1", pix_x, hsync, vsync);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_frame();
        test_lock_loss();
        test_settle_abort();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
